// File: rtl/draw_bg_scroll_if.sv
// VGA timing + colour bundle shared by the draw chain stages (interface vga_if).
interface vga_if;
  logic [10:0] vcount;
  logic [10:0] hcount;
  logic        vsync;
  logic        hsync;
  logic        vblnk;
  logic        hblnk;
  logic [11:0] rgb;

  modport in  (input  vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
  modport out (output vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
endinterface

// File: rtl/draw_bg_scroll.sv
// Background stage: coloured frame edges, vertically scrolling staggered brick fill, key passthrough.
// Optional odd-row brick shading is enabled by defining DRAW_BG_SCROLL_SHADE_EN.
//
// state  | meaning
// IDLE   | waiting for a vblnk rising edge
// UPDATE | one cycle inside vblank where the scroll position steps
module draw_bg_scroll #(
  parameter int          BORDER_W     = 1,
  parameter int          BRICK_W      = 32,
  parameter int          BRICK_H      = 16,
  parameter int          MORTAR_W     = 1,
  parameter int          SCROLL_W     = 10,
  parameter logic [11:0] FILL_COLOR   = 12'h452,
  parameter logic [11:0] MORTAR_COLOR = 12'h231,
  parameter logic [11:0] KEY_COLOR    = 12'h000,
  parameter int          HOR_PIXELS   = 1024,
  parameter int          VER_PIXELS   = 768
) (
  input  logic                clk,
  input  logic                rst_n,
  vga_if.in                   in,
  vga_if.out                  out,
  input  logic                scroll_en,
  input  logic [3:0]          scroll_step,
  input  logic                scroll_load,
  input  logic [SCROLL_W-1:0] scroll_load_val,
  output logic [SCROLL_W-1:0] scroll_pos
);

  localparam int LOG_BW = $clog2(BRICK_W);
  localparam int LOG_BH = $clog2(BRICK_H);

  localparam logic [10:0]       BORDER_LO = 11'(BORDER_W);
  localparam logic [10:0]       H_EDGE    = 11'(HOR_PIXELS - BORDER_W);
  localparam logic [10:0]       V_EDGE    = 11'(VER_PIXELS - BORDER_W);
  localparam logic [LOG_BW-1:0] HALF_BW   = LOG_BW'(BRICK_W / 2);
  localparam logic [LOG_BW-1:0] MORTAR_X  = LOG_BW'(MORTAR_W);
  localparam logic [LOG_BH-1:0] MORTAR_Y  = LOG_BH'(MORTAR_W);

  typedef enum logic {IDLE, UPDATE} state_t;

  state_t              state_q, state_d;
  logic                vblnk_d;
  logic [SCROLL_W-1:0] scroll_pos_d;

  logic [10:0]         s1_vcount, s1_hcount;
  logic                s1_vsync, s1_hsync, s1_vblnk, s1_hblnk;
  logic [11:0]         s1_rgb;
  logic [SCROLL_W-1:0] s1_y;

  logic                row_odd;
  logic [LOG_BW-1:0]   xs_low;
  logic                mortar;
  logic [11:0]         brick_color;
  logic [11:0]         color_d;

  // Scroll position FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      vblnk_d    <= 1'b0;
      scroll_pos <= '0;
    end else begin
      state_q    <= state_d;
      vblnk_d    <= in.vblnk;
      scroll_pos <= scroll_pos_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    scroll_pos_d = scroll_pos;
    case (state_q)
      IDLE: begin
        if (in.vblnk && !vblnk_d) state_d = UPDATE;
      end
      UPDATE: begin
        state_d = IDLE;
        if (scroll_en) scroll_pos_d = scroll_pos - SCROLL_W'(scroll_step);
      end
      default: state_d = IDLE;
    endcase
    // A load overrides any step, including the one due in UPDATE.
    if (scroll_load) scroll_pos_d = scroll_load_val;
  end

  // Stage 1: timing, upstream colour and scrolled row coordinate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vcount <= '0;
      s1_hcount <= '0;
      s1_vsync  <= 1'b0;
      s1_hsync  <= 1'b0;
      s1_vblnk  <= 1'b0;
      s1_hblnk  <= 1'b0;
      s1_rgb    <= '0;
      s1_y      <= '0;
    end else begin
      s1_vcount <= in.vcount;
      s1_hcount <= in.hcount;
      s1_vsync  <= in.vsync;
      s1_hsync  <= in.hsync;
      s1_vblnk  <= in.vblnk;
      s1_hblnk  <= in.hblnk;
      s1_rgb    <= in.rgb;
      s1_y      <= SCROLL_W'(in.vcount) + scroll_pos;
    end
  end

  // Odd brick rows are offset by half a brick to stagger the joints.
  assign row_odd = s1_y[LOG_BH];
  assign xs_low  = s1_hcount[LOG_BW-1:0] + (row_odd ? HALF_BW : '0);
  assign mortar  = (s1_y[LOG_BH-1:0] < MORTAR_Y) || (xs_low < MORTAR_X);

`ifdef DRAW_BG_SCROLL_SHADE_EN
  function automatic logic [11:0] shade(input logic [11:0] c);
    logic [11:0] r;
    for (int i = 0; i < 3; i++) begin
      r[i*4 +: 4] = (c[i*4 +: 4] == 4'h0) ? 4'h0 : c[i*4 +: 4] - 4'h1;
    end
    return r;
  endfunction

  assign brick_color = row_odd ? shade(FILL_COLOR) : FILL_COLOR;
`else
  assign brick_color = FILL_COLOR;
`endif

  always_comb begin
    color_d = brick_color;
    if (s1_vblnk || s1_hblnk)     color_d = 12'h000;
    else if (s1_vcount < BORDER_LO) color_d = 12'hff0;
    else if (s1_vcount >= V_EDGE)   color_d = 12'hf00;
    else if (s1_hcount < BORDER_LO) color_d = 12'h0f0;
    else if (s1_hcount >= H_EDGE)   color_d = 12'h00f;
    else if (s1_rgb != KEY_COLOR)   color_d = s1_rgb;
    else if (mortar)                color_d = MORTAR_COLOR;
  end

  // Stage 2: outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out.vcount <= '0;
      out.hcount <= '0;
      out.vsync  <= 1'b0;
      out.hsync  <= 1'b0;
      out.vblnk  <= 1'b0;
      out.hblnk  <= 1'b0;
      out.rgb    <= '0;
    end else begin
      out.vcount <= s1_vcount;
      out.hcount <= s1_hcount;
      out.vsync  <= s1_vsync;
      out.hsync  <= s1_hsync;
      out.vblnk  <= s1_vblnk;
      out.hblnk  <= s1_hblnk;
      out.rgb    <= color_d;
    end
  end

endmodule

// File: tb/tb_draw_bg_scroll.sv
// Directed bench for draw_bg_scroll (BORDER_W=2, other parameters default).
module tb_draw_bg_scroll;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scroll_en = 1'b0;
  logic [3:0] scroll_step = 4'd0;
  logic       scroll_load = 1'b0;
  logic [9:0] scroll_load_val = '0;
  logic [9:0] scroll_pos;

  int total = 0;
  int passed = 0;

  vga_if vin();
  vga_if vout();

  draw_bg_scroll #(.BORDER_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .in(vin), .out(vout),
    .scroll_en(scroll_en), .scroll_step(scroll_step),
    .scroll_load(scroll_load), .scroll_load_val(scroll_load_val),
    .scroll_pos(scroll_pos)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic set_pix(input logic [10:0] hc, input logic [10:0] vc, input logic [11:0] rgb,
                         input logic vb, input logic hb);
    vin.hcount = hc; vin.vcount = vc; vin.rgb = rgb;
    vin.vblnk = vb;  vin.hblnk = hb;
    vin.vsync = 1'b0; vin.hsync = 1'b0;
  endtask

  // Present one pixel and check the colour two cycles later (inputs held).
  task automatic pix(input string tag, input logic [10:0] hc, input logic [10:0] vc,
                     input logic [11:0] rgb, input logic vb, input logic hb,
                     input logic [11:0] exp);
    set_pix(hc, vc, rgb, vb, hb);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check(tag, 32'(vout.rgb), 32'(exp));
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      set_pix(11'($urandom), 11'($urandom), 12'($urandom), 1'($urandom), 1'($urandom));
      scroll_en = 1'($urandom); scroll_step = 4'($urandom);
      scroll_load = 1'($urandom); scroll_load_val = 10'($urandom);
      @(negedge clk);
    end
    check("rst_rgb",    32'(vout.rgb), 0);
    check("rst_hcount", 32'(vout.hcount), 0);
    check("rst_vcount", 32'(vout.vcount), 0);
    check("rst_flags",  32'({vout.vsync, vout.hsync, vout.vblnk, vout.hblnk}), 0);
    check("rst_pos",    32'(scroll_pos), 0);

    scroll_en = 1'b0; scroll_step = 4'd0; scroll_load = 1'b0; scroll_load_val = '0;
    set_pix(11'd100, 11'd100, 12'habc, 1'b0, 1'b0);
    rst_n = 1'b1;
    cyc(1);
    check("lat1_hcount", 32'(vout.hcount), 0);
    cyc(1);
    check("lat2_hcount", 32'(vout.hcount), 100);
    check("lat2_rgb",    32'(vout.rgb), 32'h abc);

    // Edges
    pix("edge_top",    11'd5,    11'd1,   12'h000, 1'b0, 1'b0, 12'hff0);
    pix("edge_bottom", 11'd5,    11'd766, 12'h000, 1'b0, 1'b0, 12'hf00);
    pix("edge_left",   11'd1,    11'd5,   12'h000, 1'b0, 1'b0, 12'h0f0);
    pix("edge_right",  11'd1023, 11'd5,   12'h000, 1'b0, 1'b0, 12'h00f);
    pix("edge_inner",  11'd2,    11'd2,   12'h000, 1'b0, 1'b0, 12'h452);
    pix("edge_beyond", 11'd1021, 11'd765, 12'h000, 1'b0, 1'b0, 12'h452);

    // Brick pattern at scroll_pos = 0
    pix("pat_fill",      11'd40, 11'd2,  12'h000, 1'b0, 1'b0, 12'h452);
    pix("pat_hmortar",   11'd40, 11'd16, 12'h000, 1'b0, 1'b0, 12'h231);
    pix("pat_odd_joint", 11'd16, 11'd17, 12'h000, 1'b0, 1'b0, 12'h231);
    pix("pat_odd_fill",  11'd32, 11'd17, 12'h000, 1'b0, 1'b0, 12'h452);
    pix("pat_even_joint",11'd32, 11'd2,  12'h000, 1'b0, 1'b0, 12'h231);

    // Passthrough and blanking
    pix("pass",     11'd100, 11'd100, 12'habc, 1'b0, 1'b0, 12'habc);
    pix("hblank",   11'd100, 11'd100, 12'habc, 1'b0, 1'b1, 12'h000);
    pix("vblank",   11'd100, 11'd100, 12'habc, 1'b1, 1'b0, 12'h000);
    set_pix(11'd100, 11'd100, 12'h000, 1'b0, 1'b0);
    cyc(2);

    // Scroll stepping on vblnk rising edges
    scroll_en = 1'b1; scroll_step = 4'd3;
    vin.vblnk = 1'b1;
    cyc(1);
    check("step1_edge+1", 32'(scroll_pos), 0);
    cyc(1);
    check("step1_edge+2", 32'(scroll_pos), 1021);
    cyc(5);
    check("step1_hold", 32'(scroll_pos), 1021);
    vin.vblnk = 1'b0;
    cyc(3);
    vin.vblnk = 1'b1;
    cyc(1);
    check("step2_edge+1", 32'(scroll_pos), 1021);
    cyc(1);
    check("step2_edge+2", 32'(scroll_pos), 1018);
    vin.vblnk = 1'b0;
    cyc(3);

    // Pattern follows the scroll: y = 14 + 1018 = 1032 mod 1024 = 8
    pix("pat_scrolled_fill", 11'd40, 11'd14, 12'h000, 1'b0, 1'b0, 12'h452);
    // y = 22 + 1018 = 16 -> horizontal mortar
    pix("pat_scrolled_mortar", 11'd40, 11'd22, 12'h000, 1'b0, 1'b0, 12'h231);

    // Disabled: position holds
    scroll_en = 1'b0;
    vin.vblnk = 1'b1;
    cyc(4);
    check("en0_hold", 32'(scroll_pos), 1018);
    vin.vblnk = 1'b0;
    cyc(3);

    // Zero step leaves position unchanged
    scroll_en = 1'b1; scroll_step = 4'd0;
    vin.vblnk = 1'b1;
    cyc(4);
    check("step0_hold", 32'(scroll_pos), 1018);
    vin.vblnk = 1'b0;
    cyc(3);

    // Load in the UPDATE cycle suppresses the step
    scroll_step = 4'd3;
    vin.vblnk = 1'b1;
    cyc(1);
    scroll_load = 1'b1; scroll_load_val = 10'h005;
    cyc(1);
    scroll_load = 1'b0;
    check("load_update", 32'(scroll_pos), 5);
    cyc(4);
    check("load_no_step", 32'(scroll_pos), 5);
    vin.vblnk = 1'b0;
    cyc(3);

    // Load while idle
    scroll_load = 1'b1; scroll_load_val = 10'h3ff;
    cyc(1);
    scroll_load = 1'b0;
    check("load_idle", 32'(scroll_pos), 32'h3ff);

    // Wrap below zero: 1 - 3 = 1022
    scroll_load = 1'b1; scroll_load_val = 10'd1;
    cyc(1);
    scroll_load = 1'b0;
    vin.vblnk = 1'b1;
    cyc(2);
    check("wrap", 32'(scroll_pos), 1022);
    vin.vblnk = 1'b0;
    cyc(2);

    // Mid-frame reset clears position and restarts the pipeline
    set_pix(11'd300, 11'd300, 12'h000, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    check("mid_rst_pos", 32'(scroll_pos), 0);
    check("mid_rst_rgb", 32'(vout.rgb), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(2);
    check("post_rst_hcount", 32'(vout.hcount), 300);
    check("post_rst_rgb",    32'(vout.rgb), 32'h452);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end
endmodule
